// File: rtl/bcd_scan_display.sv
// bcd_scan_display: latches NUM_DIGITS BCD digits into a shadow register and
// time-multiplexes them onto one seven-segment bus with a one-hot digit enable.
// The first cycle of every digit slot is blanked to suppress ghosting.
// Optional macro BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = 4 * NUM_DIGITS;

  logic [DW-1:0]         r_shadow;
  logic [PW-1:0]         r_pre_cnt;
  logic [IW-1:0]         r_idx;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  logic                  w_pre_last;
  logic                  w_idx_last;
  logic [3:0]            w_digit;
  logic                  w_blank_sel;
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic [NUM_DIGITS-1:0] w_an_onehot;

  // BCD to gfedcba; non-BCD codes show a dash
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h40;
    endcase
  endfunction

  assign w_pre_last  = (r_pre_cnt == PW'(PRESCALE - 1));
  assign w_idx_last  = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_an_onehot = NUM_DIGITS'(1) << r_idx;

`ifdef BCD_SCAN_LZ_BLANK_EN
  logic w_zero_above;

  // Blank digits that are zero with only zeros above them; digit 0 always shows
  always_comb begin
    w_lz_blank   = '0;
    w_zero_above = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      if (w_zero_above && (r_shadow[4*k +: 4] == 4'd0)) begin
        w_lz_blank[k] = 1'b1;
      end else begin
        w_zero_above = 1'b0;
      end
    end
  end
`else
  assign w_lz_blank = '0;
`endif

  // Select the active digit and its blanking flag
  always_comb begin
    w_digit     = 4'd0;
    w_blank_sel = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (r_idx == IW'(k)) begin
        w_digit     = r_shadow[4*k +: 4];
        w_blank_sel = w_lz_blank[k];
      end
    end
  end

  // Shadow capture, prescaler, digit index and registered display outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow     <= '0;
      r_pre_cnt    <= '0;
      r_idx        <= '0;
      r_seg        <= 7'h00;
      r_an         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
      end
      r_pre_cnt <= w_pre_last ? '0 : r_pre_cnt + PW'(1);
      if (w_pre_last) begin
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
      end
      r_frame_done <= w_pre_last && w_idx_last;
      if (r_pre_cnt == '0) begin
        r_an  <= '0;
        r_seg <= 7'h00;
      end else begin
        r_an  <= w_an_onehot;
        r_seg <= w_blank_sel ? 7'h00 : f_decode(w_digit);
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display (NUM_DIGITS=4, PRESCALE=4) with a scoreboard
// queue of expected outputs filled by a reference model as stimulus is driven.
module tb_bcd_scan_display;

  localparam int N = 4;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*N-1:0] digits_in;
  logic          load;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic          frame_done;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic         fd;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int checks = 0;
  int errs   = 0;

  // reference model state
  int             m_pre = 0;
  int             m_idx = 0;
  logic [4*N-1:0] m_shadow = '0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  bcd_scan_display #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [4*N-1:0] sh, input int k);
    logic [3:0] d;
    d = 4'((sh >> (4*k)) & 16'hF);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if (k > 0 && ((sh >> (4*k)) == 0)) return 7'h00;
`endif
    return dec_tab[d];
  endfunction

  // Push the expected result of this edge, update the model, drive and clock once
  task automatic tick(input logic rst, input logic ld, input logic [4*N-1:0] din);
    exp_t x;
    if (!rst) begin
      x.seg = 7'h00; x.an = '0; x.fd = 1'b0;
      m_pre = 0; m_idx = 0; m_shadow = '0;
    end else begin
      if (m_pre == 0) begin
        x.seg = 7'h00; x.an = '0;
      end else begin
        x.seg = model_seg(m_shadow, m_idx);
        x.an  = N'(1) << m_idx;
      end
      x.fd = (m_pre == P-1) && (m_idx == N-1);
      if (ld) m_shadow = din;
      if (m_pre == P-1) begin
        m_pre = 0;
        m_idx = (m_idx == N-1) ? 0 : m_idx + 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    q.push_back(x);
    reset = rst; load = ld; digits_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] an_tab [8]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2};
    logic [6:0]   seg_tab [5] = '{7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h00};
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, '0);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL reset_hold cyc%0d: got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 i, seg, an, frame_done, e.seg, e.an, e.fd);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, '0);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL reset_release edge%0d: got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 i+1, seg, an, frame_done, e.seg, e.an, e.fd);
      end
      checks++;
      if (an !== an_tab[i]) begin
        errs++;
        $display("FAIL reset_an_table edge%0d: got an=%b want %b", i+1, an, an_tab[i]);
      end
      if (i < 5) begin
        checks++;
        if (seg !== seg_tab[i]) begin
          errs++;
          $display("FAIL reset_seg_table edge%0d: got seg=%h want %h", i+1, seg, seg_tab[i]);
        end
      end
    end
  endtask

  task automatic test_decode(input logic [4*N-1:0] val, input int cycles, input string nm);
    int npulse = 0;
    int first  = -1;
    int last   = -1;
    tick(1'b1, 1'b1, val);
    e = q.pop_front();
    checks++;
    if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
      errs++;
      $display("FAIL %s load: got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
               nm, seg, an, frame_done, e.seg, e.an, e.fd);
    end
    for (int i = 0; i < cycles; i++) begin
      tick(1'b1, 1'b0, '0);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL %s cyc%0d: got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 nm, i, seg, an, frame_done, e.seg, e.an, e.fd);
      end
      if (frame_done === 1'b1) begin
        npulse++;
        if (first < 0) first = i;
        last = i;
      end
    end
    if (cycles == 32) begin
      checks++;
      if (npulse != 2 || (last - first) != 16) begin
        errs++;
        $display("FAIL %s frame_period: got pulses=%0d spacing=%0d want pulses=2 spacing=16",
                 nm, npulse, last - first);
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 40 && !(m_idx == 2 && m_pre == 3); i++) begin
      tick(1'b1, 1'b0, '0);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL midreset_pre cyc%0d: got seg=%h an=%b want seg=%h an=%b",
                 i, seg, an, e.seg, e.an);
      end
    end
    tick(1'b0, 1'b0, '0);
    e = q.pop_front();
    checks++;
    if (seg !== 7'h00 || an !== '0 || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL midreset_clear: got seg=%h an=%b fd=%b want all 0", seg, an, frame_done);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, '0);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL midreset_post cyc%0d: got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 i, seg, an, frame_done, e.seg, e.an, e.fd);
      end
      if (i == 1) begin
        checks++;
        if (seg !== 7'h3F || an !== 4'b0001) begin
          errs++;
          $display("FAIL midreset_restart: got seg=%h an=%b want seg=3f an=0001", seg, an);
        end
      end
    end
  endtask

  task automatic test_load_midslot();
    tick(1'b1, 1'b1, 16'h1987);
    void'(q.pop_front());
    for (int i = 0; i < 40 && !(m_idx == 1 && m_pre == 1); i++) begin
      tick(1'b1, 1'b0, '0);
      void'(q.pop_front());
    end
    tick(1'b1, 1'b1, 16'h0042);
    e = q.pop_front();
    checks++;
    if (seg !== 7'h7F || an !== 4'b0010 || seg !== e.seg) begin
      errs++;
      $display("FAIL midslot_old: got seg=%h an=%b want seg=7f an=0010", seg, an);
    end
    tick(1'b1, 1'b0, '0);
    e = q.pop_front();
    checks++;
    if (seg !== 7'h66 || an !== 4'b0010 || seg !== e.seg) begin
      errs++;
      $display("FAIL midslot_new: got seg=%h an=%b want seg=66 an=0010", seg, an);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, '0);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL midslot_run cyc%0d: got seg=%h an=%b want seg=%h an=%b",
                 i, seg, an, e.seg, e.an);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4*N-1:0] v;
    for (int i = 0; i < 80; i++) begin
      v = 16'($urandom);
      if ((i % 8) == 0) v = 16'h0000;
      tick(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0), v);
      e = q.pop_front();
      checks++;
      if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
        errs++;
        $display("FAIL back_to_back cyc%0d: got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                 i, seg, an, frame_done, e.seg, e.an, e.fd);
      end
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; digits_in = '0;
    test_reset();
    test_decode(16'h1987, 32, "decode_1987");
    test_decode(16'hFA05, 20, "decode_fa05");
    test_midreset();
    test_load_midslot();
    test_decode(16'h0042, 20, "decode_0042");
    test_decode(16'h0000, 20, "decode_0000");
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the decade-counter stage.
- Takes NUM_DIGITS cascaded BCD digits, latches them into a shadow register on a load strobe, and time-multiplexes them onto one shared seven-segment bus with a one-hot digit-enable bus.
- Drives the board display directly.
- All outputs are registered.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned; legal range 2..8.
- PRESCALE, 4, clock cycles each digit stays selected; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  one clock; reset is synchronous and active-low (reset=0 clears state at the next clk edge).
- digits_in  input  4*NUM_DIGITS  packed BCD digits; digit k = digits_in[4k+3:4k]; digit 0 is least significant.
- load  input  1  when 1 at a clk edge, digits_in is captured into the shadow register.
- seg  output  7  segment drive, active-high, seg[6:0] = g,f,e,d,c,b,a.
- an  output  NUM_DIGITS  digit enable, one-hot or all-zero, active-high, an[k] selects digit k.
- frame_done  output  1  one-cycle pulse when the last digit slot of a frame completes.

Behaviour:
- Reset (reset=0 at edge): shadow=0, pre_cnt=0, idx=0, seg=7'h00, an=0, frame_done=0. Reset has priority over load and over scan advance; a mid-frame reset restarts at digit 0, slot cycle 0.
- Shadow register: load=1 captures digits_in at that edge. load is level-sampled each cycle, with no handshake back-pressure. Back-to-back loads keep the last value.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - When pre_cnt==PRESCALE-1: idx advances (NUM_DIGITS-1 wraps to 0).
  - If idx==NUM_DIGITS-1 at that edge, frame_done=1 for the following cycle only.
- Anti-ghost blanking: in the cycle where pre_cnt==0 (the first cycle of each slot), an=0 and seg=0. For pre_cnt 1..PRESCALE-1, an=1<<idx and seg=decode(shadow digit idx).
- Output latency: outputs are registered from the current pre_cnt/idx/shadow.
  - A value loaded at edge t appears on seg at edge t+1 if its digit is active and not in a blank cycle.
  - First non-blank output: 2 edges after reset release.
- Decode (hex, gfedcba): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Non-BCD codes 10..15 display a dash: 7'h40.
- Frame length: NUM_DIGITS*PRESCALE cycles. frame_done period equals the frame length exactly.
- Simultaneous load and slot change: the new shadow value is used from the next edge onward; no torn digit within a slot beyond that one-edge latency.

Optional Feature:
- Macro: BCD_SCAN_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k is blanked (seg=0, an still asserted) if shadow digit k==0 and all digits above k are 0.
  - Digit 0 is never blanked, so a value of 0 displays a single "0".
  - A non-BCD digit counts as non-zero.
- Undefined: every digit is always decoded, and zeros display 3F.

Test Plan (NUM_DIGITS=4, PRESCALE=4):
1. Reset hold, then release, with shadow=0 -> edge 1: an=0, seg=00. Edges 2-4: an=0001, seg=3F. Edge 5: an=0, seg=00 (blank). Edges 6-8: an=0010.
2. load=1 with digits_in=16'h1987, then run 2 frames -> slots show digit0 seg=07, digit1 seg=7F, digit2 seg=6F, digit3 seg=06. frame_done pulses exactly every 16 cycles.
3. digits_in=16'hFA05 loaded -> digit0 seg=6D, digit1 seg=3F, digit2 (A) seg=40, digit3 (F) seg=40.
4. reset=0 for one cycle mid-frame, while idx=2 and pre_cnt=3 -> next edge: all outputs 0, idx=0. Shadow cleared to 0. No frame_done pulse.
5. load pulse with 16'h0042 during digit1 slot, pre_cnt=1 -> seg switches from the old value to 66 on the edge after the load edge. Other slots are unaffected until selected.
6. With BCD_SCAN_LZ_BLANK_EN defined and load 16'h0042 -> digit3 and digit2 give seg=00 with an asserted; digit1 seg=66; digit0 seg=5B. With 16'h0000 loaded, only digit0 shows 3F.
